sha256_block_ctrl: RTL

//  Sequencer that drives the SHA256 core for one pre-padded 512-bit block per request.
//  - Accepts a block over a valid/ready handshake.
//  - Issues soc and streams W0..W15 onto the core's shared 32-bit bus.
//  - Waits for eoc, then pulses rd 8 times to collect H0..H7.
//  - Returns the 256-bit digest over a valid/ready handshake.

---
 rtl/sha256_block_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sha256_block_ctrl.sv
// sha256_block_ctrl: feeds one pre-padded 512-bit block to an external SHA-256
// core over its shared 32-bit bus, then reads back the 256-bit digest.
//
// state | meaning
// IDLE  | ready for a new block
// LOAD  | streaming W0..W15 onto the bus, soc raised with W0
// WAIT  | bus parked at 0, waiting for eoc under the watchdog
// READ  | core_rd high, capturing H0..H7 off the bus
// DONE  | digest held until the consumer takes it
module sha256_block_ctrl #(
    parameter int TIMEOUT_CYC = 96
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         dig_valid,
    input  logic         dig_ready,
    output logic [255:0] dig_data,
    output logic         err,
    output logic         core_soc,
    output logic         core_rst,
    output logic         core_rd,
    input  logic         core_eoc,
    inout  wire  [31:0]  core_data
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_READ, S_DONE} state_t;

    // wtmr_q holds cycles elapsed since soc; the abort is decided on the
    // cycle before it would reach TIMEOUT_CYC so err shows at soc+TIMEOUT_CYC.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t         state_q, state_d;
    logic [511:0]   shreg_q, shreg_d;
    logic [255:0]   dig_q, dig_d;
    logic [3:0]     wcnt_q, wcnt_d;
    logic [2:0]     jcnt_q, jcnt_d;
    logic [7:0]     wtmr_q, wtmr_d;
    logic           err_q, err_d;
    logic           abort_q, abort_d;
    logic           timeout;
    logic           blk_hs;
    logic [31:0]    bus_out;

    assign blk_hs = blk_valid && blk_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; eoc takes priority over the watchdog in WAIT.
    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        case (state_q)
            S_IDLE: if (blk_hs) state_d = S_LOAD;
            S_LOAD: if (wcnt_q == 4'd15) state_d = S_WAIT;
            S_WAIT: begin
                if (core_eoc) begin
                    state_d = S_READ;
                end else if (wtmr_q >= TMO_LAST) begin
                    state_d = S_IDLE;
                    timeout = 1'b1;
                end
            end
            S_READ: if (jcnt_q == 3'd7) state_d = S_DONE;
            S_DONE: if (dig_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        blk_ready = (state_q == S_IDLE) && !abort_q && !rst;
        dig_valid = (state_q == S_DONE);
        core_soc  = (state_q == S_LOAD) && (wcnt_q == 4'd0);
        core_rd   = (state_q == S_READ);
        bus_out   = (state_q == S_LOAD) ? shreg_q[511:480] : 32'h0;
    end

    assign core_rst  = rst | abort_q;
    assign core_data = core_rd ? 32'hzzzz_zzzz : bus_out;
    assign dig_data  = dig_q;
    assign err       = err_q;

    // Datapath next values: block shifter, digest collector, saturating counters.
    always_comb begin
        shreg_d = shreg_q;
        dig_d   = dig_q;
        wcnt_d  = wcnt_q;
        jcnt_d  = jcnt_q;
        wtmr_d  = wtmr_q;
        err_d   = err_q | timeout;
        abort_d = timeout;
        case (state_q)
            S_IDLE: begin
                if (blk_hs) begin
                    shreg_d = blk_data;
                    wcnt_d  = 4'd0;
                    jcnt_d  = 3'd0;
                    wtmr_d  = 8'd0;
                end
            end
            S_LOAD: begin
                shreg_d = {shreg_q[479:0], 32'h0};
                if (wcnt_q != 4'd15) wcnt_d = wcnt_q + 4'd1;
                if (wtmr_q != 8'hff) wtmr_d = wtmr_q + 8'd1;
            end
            S_WAIT: begin
                if (wtmr_q != 8'hff) wtmr_d = wtmr_q + 8'd1;
                if (core_eoc) jcnt_d = 3'd0;
            end
            S_READ: begin
                dig_d = {dig_q[223:0], core_data};
                if (jcnt_q != 3'd7) jcnt_d = jcnt_q + 3'd1;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            dig_q   <= '0;
            wcnt_q  <= '0;
            jcnt_q  <= '0;
            wtmr_q  <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            dig_q   <= dig_d;
            wcnt_q  <= wcnt_d;
            jcnt_q  <= jcnt_d;
            wtmr_q  <= wtmr_d;
            err_q   <= err_d;
            abort_q <= abort_d;
        end
    end

endmodule
